// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//
// Round-robin arbiter that lets N_REQ requesters share one load-enabled
// register. The winner's data is captured when it is granted. The arbiter
// then drives the register's load enable for one cycle, pulses the
// winner's ack for one cycle, and waits HOLD_CYCLES idle cycles before it
// arbitrates again.
//
// Ports:
//   clk_i         system clock; all logic updates on the rising edge
//   rst_i         synchronous, active-high reset
//   req_i         per-requester write request, held until its ack
//   wdata_i       packed write data; requester i owns [i*WIDTH +: WIDTH]
//   ack_o         one-cycle pulse to the requester whose write completed
//   reg_ld_o      load enable to the shared register
//   reg_d_o       data to the shared register
//   busy_o        high whenever the arbiter is not idle
//   last_grant_o  index of the most recently granted requester
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 6,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*WIDTH-1:0]     wdata_i,
  output logic [N_REQ-1:0]           ack_o,
  output logic                       reg_ld_o,
  output logic [WIDTH-1:0]           reg_d_o,
  output logic                       busy_o,
  output logic [$clog2(N_REQ)-1:0]   last_grant_o
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACK,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   lastGrant_q, lastGrant_d;
  logic [WIDTH-1:0] regD_q, regD_d;
  logic [CW-1:0]   holdCnt_q, holdCnt_d;

  logic            found;
  logic [GW-1:0]   winIdx;
  logic [WIDTH-1:0] winData;
  logic [GW-1:0]   candIdx;

  // Round-robin search: start one past the last winner and wrap, so the
  // requester that was just served has the lowest priority next time.
  always_comb begin
    found   = 1'b0;
    winIdx  = '0;
    winData = '0;
    candIdx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      candIdx = GW'((int'(lastGrant_q) + k) % N_REQ);
      if (!found && req_i[candIdx]) begin
        found   = 1'b1;
        winIdx  = candIdx;
        winData = wdata_i[candIdx*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and output logic. The data is captured at grant time, so
  // later changes on wdata_i cannot corrupt a write that is in flight.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    regD_d      = regD_q;
    holdCnt_d   = holdCnt_q;
    ack_o       = '0;
    reg_ld_o    = 1'b0;
    busy_o      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (found) begin
          lastGrant_d = winIdx;
          regD_d      = winData;
          state_d     = LOAD;
        end
      end

      LOAD: begin
        reg_ld_o = 1'b1;
        state_d  = ACK;
      end

      ACK: begin
        // A reset that lands on the ack cycle cancels the ack. The
        // requester then keeps its request up and is re-arbitrated.
        if (!rst_i) begin
          ack_o[lastGrant_q] = 1'b1;
        end
        if (HOLD_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d   = HOLD;
          holdCnt_d = CW'(HOLD_CYCLES);
        end
      end

      HOLD: begin
        holdCnt_d = holdCnt_q - CW'(1);
        if (holdCnt_q <= CW'(1)) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. The reset leaves last grant at the top index so that
  // requester 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lastGrant_q <= GW'(N_REQ - 1);
      regD_q      <= '0;
      holdCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      regD_q      <= regD_d;
      holdCnt_q   <= holdCnt_d;
    end
  end

  assign reg_d_o      = regD_q;
  assign last_grant_o = lastGrant_q;

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares one 6-bit load-enabled register (clk, rst, load enable, 6-bit d/q) between N_REQ requesters.
- Captures the winning requester's data and drives the register's load enable and data for exactly one cycle.
- Acknowledges the winner, then enforces a programmable hold-off before the next write.
- Sits between game/control FSMs and the shared state register in the final-project datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 6, register data width; must match the shared register.
- HOLD_CYCLES, 2, idle cycles enforced after each ack before the next arbitration (0..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester write request; held high until matching ack.
- wdata  input  N_REQ*WIDTH  packed write data; requester i owns bits [i*WIDTH +: WIDTH].
- ack  output  N_REQ  one-cycle pulse to the requester whose write completed.
- reg_ld  output  1  load enable to the shared register.
- reg_d  output  WIDTH  data to the shared register.
- busy  output  1  high in every state except IDLE.
- last_grant  output  $clog2(N_REQ)  index of the most recently granted requester.

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE; ack=0, reg_ld=0, reg_d=0, busy=0.
  - last_grant=N_REQ-1, so requester 0 has highest priority first. Hold counter=0.
- States: IDLE, LOAD, ACK, HOLD.
- IDLE:
  - If any req bit is high, pick the first set bit searching upward from (last_grant+1) mod N_REQ, wrapping.
  - Register the winner index into last_grant and its wdata slice into reg_d; next state LOAD.
  - Otherwise stay in IDLE.
- LOAD: exactly one cycle.
  - reg_ld=1; reg_d holds the captured data. The shared register updates at the end of this cycle.
  - Next state ACK.
- ACK: exactly one cycle.
  - ack[last_grant]=1, all other ack bits 0; reg_ld=0.
  - Next state HOLD, with the counter loaded to HOLD_CYCLES. If HOLD_CYCLES=0, next state is IDLE directly.
- HOLD:
  - Decrement the counter each cycle; leave to IDLE when the counter reaches 1 (decrementing to 0).
  - HOLD lasts exactly HOLD_CYCLES cycles. req is ignored.
- Latency:
  - Request seen in IDLE at edge N: reg_ld is high in cycle N+1, ack in cycle N+2.
  - Next arbitration happens at edge N+3+HOLD_CYCLES.
- reg_d is held stable outside LOAD; it keeps the last written value, and is 0 after reset.
- Data is captured at grant. wdata changes after grant do not affect the write.
- Requester rules:
  - Drops req in the cycle after ack.
  - If req is still high when IDLE is re-entered, it is a new request and round-robin priority applies, so others win first if pending.
- Request withdrawn after grant (during LOAD/ACK/HOLD): the write still completes and ack still pulses.
- Multiple simultaneous requests are served one at a time in rotating order; no requester is starved.
- Reset mid-operation (any state):
  - Return to IDLE next cycle; no ack is issued.
  - If rst coincides with LOAD, reg_ld is forced 0 from the next cycle; the shared register is also reset by rst.
  - Pending requesters keep req high and are re-arbitrated.
- busy=1 in LOAD, ACK, HOLD.

Test Plan:
- Reset then req=0001, wdata[5:0]=6'h2A (HOLD_CYCLES=2) -> reg_ld high in cycle 2 with reg_d=2A; ack=0001 in cycle 3; busy low at cycle 6; last_grant=0.
- req=1111 held, each slice i = i+5 -> writes occur in order 0,1,2,3,0 with reg_d 05,06,07,08,05; every ack is a single-cycle pulse; writes are spaced 3+HOLD_CYCLES apart.
- After a grant to 2, req=0101 -> the next grant is 0 (wrap past 3), then 2.
- Grant to 1 with wdata slice 6'h11, change the slice to 6'h3F during LOAD -> reg_d=11; the register q ends at 11.
- rst pulsed during ACK, req=0010 held -> no ack this round; after reset, grant goes to 1 and completes with ack=0010.
- HOLD_CYCLES=0 build, req=0011 held -> back-to-back writes 3 cycles apart; reg_ld is never high two consecutive cycles.
